// File: rtl/io_digit_engine.sv
// rtl/io_digit_engine.sv - digit-serial I/O engine with input code FIFO and output symbol sequencer
module io_digit_engine #(
    parameter int WORD_W     = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_dec,
    input  logic              continuous,
    input  logic              in_start,
    input  logic              in_stop,
    input  logic              in_val_from_dev,
    input  logic [4:0]        in_data_from_dev,
    output logic              in_rdy_to_dev,
    output logic              in_active,
    output logic [WORD_W-1:0] in_word,
    output logic              in_sign,
    output logic              in_word_valid,
    input  logic              in_word_ack,
    output logic              in_overflow,
    input  logic              out_start,
    input  logic [WORD_W-1:0] out_word,
    input  logic              out_sign,
    input  logic              out_stop,
    output logic              out_rdy_to_dev,
    input  logic              out_ack_from_dev,
    output logic [4:0]        out_data_to_dev,
    output logic              out_active,
    output logic              out_done
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int NDIG3 = (WORD_W + 2) / 3;
    localparam int NDIG4 = (WORD_W + 3) / 4;
    localparam int PW3   = NDIG3 * 3;
    localparam int PW4   = NDIG4 * 4;
    localparam int SW    = (PW3 > PW4) ? PW3 : PW4;
    localparam int IW    = $clog2(NDIG3 + 2) + 1;

    typedef enum logic [1:0] {O_IDLE, O_RDY, O_ACK, O_NEXT} o_state_t;

    logic [4:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;
    logic              mode_reg;

    logic              in_start_acc;
    logic              out_start_acc;
    logic              push;
    logic              pop;
    logic [4:0]        head;
    logic [4:0]        head_m;
    logic              pop_digit;
    logic              pop_neg;
    logic              pop_pos;
    logic              pop_write;
    logic              pop_end;
    logic              ack_fire;
    logic              in_end;
    logic [WORD_W-1:0] digit_word;
    logic              digit_lost;

    o_state_t          o_state;
    logic [IW-1:0]     o_index;
    logic [SW-1:0]     o_shift;
    logic [IW-1:0]     ndig;
    logic [SW-1:0]     shift_adv;
    logic [3:0]        next_digit;
    logic [4:0]        next_code;
    logic [SW-1:0]     load_shift;

    // Session arbitration: stop beats start, input beats output, sessions are exclusive
    assign in_start_acc  = in_start && !in_stop && !in_active && !out_active;
    assign out_start_acc = out_start && !out_stop && !out_active && !in_active && !in_start_acc;

    assign in_rdy_to_dev = in_active && (fifo_count != CW'(FIFO_DEPTH));
    assign push          = in_rdy_to_dev && in_val_from_dev;
    assign pop           = in_active && (fifo_count != '0) && !in_word_valid;
    assign head          = fifo_mem[rd_ptr];
    assign head_m        = head & 5'b10111;
    assign pop_digit     = pop && head[4];
    assign pop_neg       = pop && (head_m == 5'b00010);
    assign pop_pos       = pop && (head_m == 5'b00011);
    assign pop_write     = pop && (head_m == 5'b00110);
    assign pop_end       = pop && (head_m == 5'b00111);
    assign ack_fire      = in_word_valid && in_word_ack;
    assign in_end        = in_active && (in_stop || pop_end || (ack_fire && !continuous));

    // Digit shift-in and detection of nonzero bits falling off the top of the word
    always_comb begin
        digit_word = '0;
        digit_lost = 1'b0;
        if (mode_reg) begin
            digit_word = (in_word << 4) | WORD_W'(head[3:0]);
            digit_lost = |in_word[WORD_W-1 -: 4];
        end else begin
            digit_word = (in_word << 3) | WORD_W'(head[2:0]);
            digit_lost = |in_word[WORD_W-1 -: 3];
        end
    end

    // Output symbol generation: word is left-aligned so the first digit sits at the top
    always_comb begin
        ndig       = mode_reg ? IW'(NDIG4) : IW'(NDIG3);
        shift_adv  = o_shift;
        if (o_index != '0) begin
            shift_adv = mode_reg ? (o_shift << 4) : (o_shift << 3);
        end
        next_digit = mode_reg ? shift_adv[SW-1 -: 4] : {1'b0, shift_adv[SW-1 -: 3]};
        next_code  = mode_reg ? {1'b1, next_digit} : {2'b10, next_digit[2:0]};
        if (o_index == ndig) begin
            next_code = 5'b00110;
        end
        load_shift = mode_dec ? (SW'(out_word) << (SW - PW4)) : (SW'(out_word) << (SW - PW3));
    end

    // FIFO storage; occupancy is tracked by fifo_count so contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data_from_dev;
        end
    end

    // Digit width is fixed for the whole session at the accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg <= 1'b0;
        end else if (in_start_acc || out_start_acc) begin
            mode_reg <= mode_dec;
        end
    end

    // Input session control, FIFO pointers and code decode into word/sign
    always_ff @(posedge clk) begin
        if (reset) begin
            in_active     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            in_word       <= '0;
            in_sign       <= 1'b0;
            in_word_valid <= 1'b0;
            in_overflow   <= 1'b0;
        end else if (in_start_acc) begin
            in_active     <= 1'b1;
            in_overflow   <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            in_word_valid <= 1'b0;
        end else if (in_end) begin
            in_active     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            in_word_valid <= 1'b0;
            if (ack_fire) begin
                in_word <= '0;
                in_sign <= 1'b0;
            end
        end else if (in_active) begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (ack_fire) begin
                in_word_valid <= 1'b0;
                in_word       <= '0;
                in_sign       <= 1'b0;
            end else if (pop_digit) begin
                in_word <= digit_word;
                if (digit_lost) begin
                    in_overflow <= 1'b1;
                end
            end else if (pop_neg) begin
                in_sign <= 1'b1;
            end else if (pop_pos) begin
                in_sign <= 1'b0;
            end else if (pop_write) begin
                in_word_valid <= 1'b1;
            end
        end
    end

    // Output FSM: sign, digits MSB first, end code, each with a 4-phase handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            o_state         <= O_IDLE;
            o_index         <= '0;
            o_shift         <= '0;
            out_rdy_to_dev  <= 1'b0;
            out_data_to_dev <= 5'b00000;
            out_active      <= 1'b0;
            out_done        <= 1'b0;
        end else begin
            out_done <= 1'b0;
            if (out_stop) begin
                o_state         <= O_IDLE;
                out_rdy_to_dev  <= 1'b0;
                out_data_to_dev <= 5'b00000;
                out_active      <= 1'b0;
            end else begin
                case (o_state)
                    O_IDLE: begin
                        if (out_start_acc) begin
                            o_state         <= O_RDY;
                            o_index         <= '0;
                            o_shift         <= load_shift;
                            out_rdy_to_dev  <= 1'b1;
                            out_data_to_dev <= {4'b1111, out_sign};
                            out_active      <= 1'b1;
                        end
                    end
                    O_RDY: begin
                        if (out_ack_from_dev) begin
                            o_state        <= O_ACK;
                            out_rdy_to_dev <= 1'b0;
                        end
                    end
                    O_ACK: begin
                        if (!out_ack_from_dev) begin
                            o_state <= O_NEXT;
                        end
                    end
                    O_NEXT: begin
                        if (o_index == ndig + IW'(1)) begin
                            o_state         <= O_IDLE;
                            out_data_to_dev <= 5'b00000;
                            out_active      <= 1'b0;
                            out_done        <= 1'b1;
                        end else begin
                            o_state         <= O_RDY;
                            o_index         <= o_index + IW'(1);
                            o_shift         <= shift_adv;
                            out_data_to_dev <= next_code;
                            out_rdy_to_dev  <= 1'b1;
                        end
                    end
                    default: o_state <= O_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_digit_engine.sv
// tb/tb_io_digit_engine.sv - self-checking bench for io_digit_engine
module tb_io_digit_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_dec;
    logic        continuous;
    logic        in_start;
    logic        in_stop;
    logic        in_val_from_dev;
    logic [4:0]  in_data_from_dev;
    logic        in_rdy_to_dev;
    logic        in_active;
    logic [29:0] in_word;
    logic        in_sign;
    logic        in_word_valid;
    logic        in_word_ack;
    logic        in_overflow;
    logic        out_start;
    logic [29:0] out_word;
    logic        out_sign;
    logic        out_stop;
    logic        out_rdy_to_dev;
    logic        out_ack_from_dev;
    logic [4:0]  out_data_to_dev;
    logic        out_active;
    logic        out_done;

    always #5 clk = ~clk;

    io_digit_engine #(.WORD_W(30), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .mode_dec(mode_dec), .continuous(continuous),
        .in_start(in_start), .in_stop(in_stop), .in_val_from_dev(in_val_from_dev),
        .in_data_from_dev(in_data_from_dev), .in_rdy_to_dev(in_rdy_to_dev),
        .in_active(in_active), .in_word(in_word), .in_sign(in_sign),
        .in_word_valid(in_word_valid), .in_word_ack(in_word_ack), .in_overflow(in_overflow),
        .out_start(out_start), .out_word(out_word), .out_sign(out_sign), .out_stop(out_stop),
        .out_rdy_to_dev(out_rdy_to_dev), .out_ack_from_dev(out_ack_from_dev),
        .out_data_to_dev(out_data_to_dev), .out_active(out_active), .out_done(out_done)
    );

    typedef struct {
        logic        dec;
        logic [29:0] word;
        logic        sign;
        int          hs;
        logic [4:0]  first;
    } ovec_t;

    ovec_t       ovec [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [4:0]  sb_out [$];
    logic [30:0] sb_in [$];
    logic [4:0]  stim_q [$];
    logic [29:0] m_word;
    logic        m_sign;
    logic        m_dead;
    logic        m_dec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {in_start, in_stop, in_val_from_dev, in_word_ack, out_start, out_stop, out_ack_from_dev} = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_out.delete();
        sb_in.delete();
        m_word = '0;
        m_sign = 1'b0;
        m_dead = 1'b1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_in_rdy"}, in_rdy_to_dev, 0);
        check({p, "_in_active"}, in_active, 0);
        check({p, "_in_word"}, in_word, 0);
        check({p, "_in_sign"}, in_sign, 0);
        check({p, "_in_valid"}, in_word_valid, 0);
        check({p, "_in_ovf"}, in_overflow, 0);
        check({p, "_out_rdy"}, out_rdy_to_dev, 0);
        check({p, "_out_data"}, out_data_to_dev, 0);
        check({p, "_out_active"}, out_active, 0);
        check({p, "_out_done"}, out_done, 0);
    endtask

    // Expected output symbol stream, built by repeated division of the word
    task automatic push_out_exp(input logic dec, input logic [29:0] w, input logic s);
        int          dd;
        int          nd;
        logic [29:0] dig;
        dd = dec ? 4 : 3;
        nd = (30 + dd - 1) / dd;
        sb_out.push_back({4'b1111, s});
        for (int k = nd - 1; k >= 0; k--) begin
            dig = (w >> (k * dd)) & (dec ? 30'd15 : 30'd7);
            sb_out.push_back(dec ? {1'b1, dig[3:0]} : {2'b10, dig[2:0]});
        end
        sb_out.push_back(5'b00110);
    endtask

    task automatic run_output(input string nm, input logic dec, input logic [29:0] w, input logic s,
                              input int exp_hs, input logic [4:0] exp_first, input int stop_at);
        int         hs = 0;
        int         done_cnt = 0;
        int         phase = 0;
        int         dly = 0;
        bit         fin = 0;
        logic [4:0] e;
        push_out_exp(dec, w, s);
        @(negedge clk);
        mode_dec = dec; out_word = w; out_sign = s; out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0;
        check({nm, "_active"}, out_active, 1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (out_done) begin
                done_cnt++;
                fin = 1;
            end
            case (phase)
                0: if (out_rdy_to_dev) begin
                    hs++;
                    if (sb_out.size() == 0) check({nm, "_extra_code"}, out_rdy_to_dev, 0);
                    else begin
                        e = sb_out.pop_front();
                        check({nm, "_code"}, out_data_to_dev, e);
                    end
                    if (hs == 2) check({nm, "_first_digit"}, out_data_to_dev, exp_first);
                    if (hs == stop_at) begin
                        out_stop = 1'b1;
                        fin = 1;
                    end
                    dly = 2;
                    phase = 1;
                end
                1: begin
                    dly--;
                    if (dly == 0) begin
                        out_ack_from_dev = 1'b1;
                        phase = 2;
                    end
                end
                default: if (!out_rdy_to_dev) begin
                    out_ack_from_dev = 1'b0;
                    phase = 0;
                end
            endcase
        end
        check({nm, "_no_timeout"}, fin, 1);
        if (stop_at > 0) begin
            @(negedge clk);
            out_stop = 1'b0;
            check({nm, "_stop_rdy"}, out_rdy_to_dev, 0);
            check({nm, "_stop_data"}, out_data_to_dev, 0);
        end
        out_ack_from_dev = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (out_done) done_cnt++;
        end
        check({nm, "_done_count"}, done_cnt, (stop_at > 0) ? 0 : 1);
        if (stop_at == 0) begin
            check({nm, "_handshakes"}, hs, exp_hs);
            check({nm, "_sb_left"}, sb_out.size(), 0);
        end
        check({nm, "_inactive"}, out_active, 0);
        sb_out.delete();
    endtask

    // Reference decode of one accepted code, in push order
    task automatic model_code(input logic [4:0] c);
        if (!m_dead) begin
            if (c[4]) m_word = m_dec ? {m_word[25:0], c[3:0]} : {m_word[26:0], c[2:0]};
            else begin
                case (c & 5'b10111)
                    5'b00010: m_sign = 1'b1;
                    5'b00011: m_sign = 1'b0;
                    5'b00110: begin
                        sb_in.push_back({m_sign, m_word});
                        m_word = '0;
                        m_sign = 1'b0;
                        if (!continuous) m_dead = 1'b1;
                    end
                    5'b00111: m_dead = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic start_input(input logic dec, input logic cont);
        @(negedge clk);
        mode_dec = dec; continuous = cont; in_start = 1'b1;
        m_dec = dec; m_dead = 1'b0;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic run_input(input string nm, input int ack_dly, input int budget, input int snap_cyc,
                             output int acc, output int stores, output int snap_acc, output logic snap_rdy);
        int          wc = 0;
        logic [30:0] e;
        acc = 0; stores = 0; snap_acc = -1; snap_rdy = 1'bx;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (in_word_ack) in_word_ack = 1'b0;
            else if (in_word_valid) begin
                if (wc == 0) begin
                    if (sb_in.size() == 0) check({nm, "_unexpected_store"}, in_word_valid, 0);
                    else begin
                        e = sb_in.pop_front();
                        check({nm, "_store_word"}, in_word, e[29:0]);
                        check({nm, "_store_sign"}, in_sign, e[30]);
                    end
                end
                wc++;
                if (wc > ack_dly) begin
                    in_word_ack = 1'b1;
                    wc = 0;
                    stores++;
                end
            end
            if (acc < stim_q.size()) begin
                in_val_from_dev = 1'b1;
                in_data_from_dev = stim_q[acc];
                if (in_rdy_to_dev) begin
                    model_code(stim_q[acc]);
                    acc++;
                end
            end else in_val_from_dev = 1'b0;
            if (cyc == snap_cyc) begin
                snap_acc = acc;
                snap_rdy = in_rdy_to_dev;
            end
        end
        in_val_from_dev = 1'b0;
        in_word_ack = 1'b0;
    endtask

    initial begin
        int   acc;
        int   st;
        int   sa;
        logic sr;
        reset = 1'b1;
        {mode_dec, continuous, in_start, in_stop, in_val_from_dev, in_word_ack} = '0;
        {out_start, out_sign, out_stop, out_ack_from_dev} = '0;
        in_data_from_dev = '0;
        out_word = '0;

        ovec[0] = '{dec: 1'b0, word: 30'o1234567012, sign: 1'b1, hs: 12, first: 5'b10001};
        ovec[1] = '{dec: 1'b1, word: 30'h2ABCDEF1,   sign: 1'b0, hs: 10, first: 5'b10010};
        ovec[2] = '{dec: 1'b0, word: 30'o0,          sign: 1'b0, hs: 12, first: 5'b10000};
        ovec[3] = '{dec: 1'b1, word: 30'h3FFFFFFF,   sign: 1'b1, hs: 10, first: 5'b10011};

        do_reset();
        check_zero("reset");

        for (int i = 0; i < 4; i++) begin
            run_output($sformatf("out_vec%0d", i), ovec[i].dec, ovec[i].word, ovec[i].sign,
                       ovec[i].hs, ovec[i].first, 0);
        end
        run_output("out_stop", 1'b0, 30'o7654321, 1'b0, 0, 5'b10000, 2);

        // Burst: FIFO fills behind a pending store, then the end code closes the session
        do_reset();
        stim_q = '{5'b00010, 5'b10101, 5'b10111, 5'b00110, 5'b00111, 5'b10001, 5'b10001, 5'b10001,
                   5'b10001, 5'b10001};
        start_input(1'b0, 1'b1);
        check("burst_rdy_after_start", in_rdy_to_dev, 1);
        run_input("burst", 8, 25, 10, acc, st, sa, sr);
        check("burst_accepted_at_full", sa, 8);
        check("burst_rdy_when_full", sr, 0);
        check("burst_accepted_total", acc, 8);
        check("burst_stores", st, 1);
        check("burst_active_after_end", in_active, 0);
        check("burst_valid_after_end", in_word_valid, 0);
        check("burst_word_cleared", in_word, 0);
        check("burst_sb_left", sb_in.size(), 0);

        // Continuous: two independent stores, session stays open until stopped
        stim_q = '{5'b10001, 5'b10010, 5'b00110, 5'b00100, 5'b00011, 5'b10111, 5'b00010, 5'b00110};
        start_input(1'b0, 1'b1);
        run_input("cont", 2, 40, 0, acc, st, sa, sr);
        check("cont_stores", st, 2);
        check("cont_still_active", in_active, 1);
        check("cont_sb_left", sb_in.size(), 0);
        @(negedge clk);
        in_stop = 1'b1;
        @(negedge clk);
        in_stop = 1'b0;
        check("cont_stop_inactive", in_active, 0);
        check("cont_stop_rdy", in_rdy_to_dev, 0);

        // Decimal digits: a write ends a non-continuous session, an end code holds the word
        stim_q = '{5'b11010, 5'b10011, 5'b00110};
        start_input(1'b1, 1'b0);
        run_input("dec_write", 1, 20, 0, acc, st, sa, sr);
        check("dec_write_stores", st, 1);
        check("dec_write_inactive", in_active, 0);
        stim_q = '{5'b10101, 5'b00111};
        start_input(1'b1, 1'b0);
        run_input("dec_end", 1, 15, 0, acc, st, sa, sr);
        check("dec_end_word_held", in_word, 30'h5);
        check("dec_end_inactive", in_active, 0);
        check("dec_end_stores", st, 0);

        // Overflow: ten oct digits fill the word exactly, the eleventh spills ones
        do_reset();
        stim_q = '{10{5'b10111}};
        stim_q.push_back(5'b00111);
        start_input(1'b0, 1'b0);
        run_input("ovf10", 1, 25, 0, acc, st, sa, sr);
        check("ovf10_flag", in_overflow, 0);
        check("ovf10_word", in_word, 30'h3FFFFFFF);
        stim_q = '{5'b10111, 5'b00111};
        start_input(1'b0, 1'b0);
        run_input("ovf11", 1, 10, 0, acc, st, sa, sr);
        check("ovf11_flag", in_overflow, 1);
        check("ovf11_word", in_word, 30'h3FFFFFFF);
        start_input(1'b0, 1'b0);
        check("ovf_cleared_on_start", in_overflow, 0);
        in_stop = 1'b1;
        @(negedge clk);
        in_stop = 1'b0;

        // Arbitration: simultaneous starts favour input; stop beats start
        @(negedge clk);
        in_start = 1'b1; out_start = 1'b1; out_word = 30'o17;
        @(negedge clk);
        in_start = 1'b0; out_start = 1'b0;
        check("arb_in_active", in_active, 1);
        check("arb_out_idle", out_active, 0);
        out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0;
        check("arb_out_blocked", out_active, 0);
        in_stop = 1'b1;
        @(negedge clk);
        in_stop = 1'b0;
        check("arb_in_stopped", in_active, 0);
        in_start = 1'b1; in_stop = 1'b1;
        @(negedge clk);
        in_start = 1'b0; in_stop = 1'b0;
        check("arb_stop_over_start", in_active, 0);

        // Reset while a store is pending
        stim_q = '{5'b00010, 5'b10101, 5'b00110};
        start_input(1'b0, 1'b0);
        run_input("rst_store", 100, 10, 0, acc, st, sa, sr);
        check("rst_store_pending", in_word_valid, 1);
        do_reset();
        check_zero("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
